hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_controller_sat_counter.sv | 16 +
 rtl/hazard_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and default parameters for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {HOLD, RUN, FREEZE, HALT} state_e;
  localparam logic [4:0] XZR = 5'd31;
  localparam int unsigned WDT_LIMIT_DEF = 255;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned HOLD_CYC_DEF = 2;
  function automatic logic load_use(input logic mem_read, input logic [4:0] rd,
                                    input logic [4:0] rn, input logic [4:0] rm, input logic uses_rm);
    return mem_read && (rd != XZR) && ((rd == rn) || (uses_rm && rd == rm));
  endfunction
endpackage

// File: rtl/hazard_controller_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] q_d;
  always_comb q_d = clr ? '0 : (inc && q != '1) ? q + 1'b1 : q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q <= '0;
    else q <= q_d;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/freeze control for a 5-stage pipeline with a memory
// watchdog and saturating performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = WDT_LIMIT_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [4:0]       IF_ID_Rn,
  input  logic [4:0]       IF_ID_Rm,
  input  logic             IF_ID_UsesRm,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             BranchTaken,
  input  logic             MemBusy,
  input  logic             CntClear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             PipeEn,
  output logic             ID_EX_Bubble,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Flush_EX_MEM,
  output logic             Fault,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] FreezeCnt
);
  state_e state_q, state_d;
  logic [7:0] hold_q, hold_d, wdt_q, wdt_d;
  logic fault_q, fault_d;
  logic stall_inc, flush_inc, freeze_inc, flush_all, active, hazard;
  assign hazard = load_use(ID_EX_MemRead, ID_EX_Rd, IF_ID_Rn, IF_ID_Rm, IF_ID_UsesRm);
  assign active = (state_q == RUN) || (state_q == FREEZE);
  assign Flush_IF_ID = flush_all;
  assign Flush_ID_EX = flush_all;
  assign Flush_EX_MEM = flush_all;
  assign Fault = fault_q;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    wdt_d = wdt_q;
    PCWrite = 1'b1;
    IF_ID_Write = 1'b1;
    PipeEn = 1'b1;
    ID_EX_Bubble = 1'b0;
    flush_all = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    freeze_inc = 1'b0;
    if (state_q == HOLD) begin
      {PCWrite, IF_ID_Write, PipeEn, flush_all} = 4'b0001;
      hold_d = hold_q + 8'd1;
      if (hold_q == 8'(HOLD_CYC - 1)) begin
        state_d = RUN;
        hold_d = '0;
      end
    end else if (state_q == HALT) begin
      {PCWrite, IF_ID_Write, PipeEn} = 3'b000;
    end else if (MemBusy) begin
      {PCWrite, IF_ID_Write, PipeEn} = 3'b000;
      freeze_inc = 1'b1;
      wdt_d = wdt_q + 8'd1;
      state_d = (wdt_d == 8'(WDT_LIMIT)) ? HALT : FREEZE;
    end else begin
      // Leaving FREEZE is itself a RUN cycle, so a held branch is taken here.
      wdt_d = '0;
      state_d = RUN;
      if (BranchTaken) begin
        flush_all = 1'b1;
        flush_inc = 1'b1;
      end else if (hazard) begin
        {PCWrite, IF_ID_Write, ID_EX_Bubble} = 3'b001;
        stall_inc = 1'b1;
      end
    end
    fault_d = fault_q || (state_d == HALT);
  end
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= HOLD;
      hold_q <= '0;
      wdt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      wdt_q <= wdt_d;
      fault_q <= fault_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (.clk_i(CLOCK), .rst_ni(RESET_N), .inc(stall_inc),
    .clr(CntClear && active), .q(StallCnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush (.clk_i(CLOCK), .rst_ni(RESET_N), .inc(flush_inc),
    .clr(CntClear && active), .q(FlushCnt));
  sat_counter #(.CNT_W(CNT_W)) u_freeze (.clk_i(CLOCK), .rst_ni(RESET_N), .inc(freeze_inc),
    .clr(CntClear && active), .q(FreezeCnt));
endmodule
